seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display bank, generalising the single-digit hex decoder to N digits with per-digit decimal point, anti-ghost blanking and tear-free frame-synchronous updates. Sits between the status/debug logic (which presents a packed hex value) and the board's segment/digit pins.

## Interface
- DIGITS, 4: number of digits scanned; 1..16.
- ON_CYCLES, 1000: clock cycles each digit is driven per scan slot; ≥1.
- GHOST_CYCLES, 16: all-off cycles before each digit slot; ≥1.
- SEG_ACTIVE_LOW, 1: 1 = segment/dp pins active low.
- DIG_ACTIVE_LOW, 1: 1 = digit-select pins active low.
- clock  input  1  system clock, posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scan; 0 = display dark.
- value  input  4*DIGITS  hex nibbles; value[3:0] is digit 0 (rightmost).
- dp  input  DIGITS  decimal point per digit, active high.
- load  input  1  one-cycle strobe: stage value/dp.
- seg  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a, polarity per SEG_ACTIVE_LOW.
- dpOut  output  1  decimal-point pin, polarity per SEG_ACTIVE_LOW.
- digitSel  output  DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW.
- frameDone  output  1  one-cycle pulse at end of each full scan.

## Operation
- Registers: staged {value,dp}, shadow {value,dp}, pending flag, state, cycle counter (width $clog2(max(ON_CYCLES,GHOST_CYCLES))), digit index (width $clog2(DIGITS), min 1).
- States: OFF, BLANK, ON.
  - OFF: outputs inactive; counter=0, index=0. enable=1 -> BLANK.
  - BLANK: outputs inactive; after GHOST_CYCLES cycles -> ON.
  - ON: digitSel active on index, seg/dpOut from shadow nibble/dp; after ON_CYCLES cycles -> BLANK, index+1.
  - enable=0 in any state -> OFF next cycle.
- Index wraps DIGITS-1 -> 0 (non-power-of-two DIGITS must wrap, never reach DIGITS); the wrap cycle pulses frameDone.
- load: staged <= {value,dp}, pending <= 1. Repeated loads within a frame: last wins.
- Shadow update: on the frameDone cycle if pending or load is asserted that same cycle (value on the bus that cycle wins); pending cleared. In OFF, shadow updates directly from load, same cycle as staging.
- Glyphs (active-high, abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Polarity inversion applied after decode.

## Timing
- All outputs registered; reset values: seg/dpOut/digitSel inactive level, frameDone=0, state OFF, shadow/staged/pending 0.
- enable rising edge to first active digitSel: GHOST_CYCLES+1 cycles.
- Scan slot length: GHOST_CYCLES+ON_CYCLES; frame period DIGITS×(GHOST_CYCLES+ON_CYCLES).
- A new shadow value is first visible on digit 0 of the next frame; never mid-frame.
- enable fall: all outputs inactive on the next clock edge.
- reset asserted mid-scan: outputs inactive immediately (asynchronous), state OFF, pending load discarded.
- Never more than one digitSel active; none active in BLANK/OFF.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: during ON, a digit whose nibble and all higher nibbles in shadow are zero drives all segments inactive; digit 0 always shown; dpOut still driven from dp. Undefined: every digit shows its glyph, including leading zeros.

## Structure
- seg7_pkg: state enum (OFF/BLANK/ON), 16-entry glyph constant array, polarity-apply function.
- Sub-module seg7_slot_timer: counter + state machine emitting slot index, blank/on phase and frameDone; top holds staging/shadow, decode and output registers.

## Test plan
- Reset with enable=1, DIGITS=4, ON=4, GHOST=2: outputs inactive during reset; first digitSel=4'b1110 exactly 3 cycles after reset release.
- load value=16'h12AF, dp=4'b0100 mid-frame: old shadow shown until frameDone; next frame digit0 seg=~7'b1000111, digit2 dpOut=0, digit3 seg=~7'b0110000.
- load on the same cycle as frameDone with 16'h0007: next frame shows 7 on digit 0; no extra frame delay.
- enable dropped during ON of digit 2: next cycle digitSel=4'b1111, seg=7'h7F; re-enable restarts at digit 0 after GHOST.
- DIGITS=3: index sequence 0,1,2,0; frameDone once per 3 slots; digitSel one-hot every ON cycle.
- With SEG7_LEADING_ZERO_BLANK_EN, value=16'h0040: digits 3,2 dark, digit1 shows 4, digit0 shows 0; without macro all four lit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } seg7_state_t;

    // Active-high {a,b,c,d,e,f,g}, indexed by hex nibble.
    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] raw, input logic active_low);
        return active_low ? ~raw : raw;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned w;
        w = $clog2((a > b) ? a : b);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Scan sequencer: OFF -> BLANK -> ON per digit slot, index wrap and frameDone.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned ON_CYCLES    = 1000,
    parameter int unsigned GHOST_CYCLES = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    output logic                           nxtOn,
    output logic [idx_width(DIGITS)-1:0]   nxtIdx,
    output logic                           isOff,
    output logic                           frameDone
);

    localparam int unsigned IW = idx_width(DIGITS);
    localparam int unsigned CW = cnt_width(ON_CYCLES, GHOST_CYCLES);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GHOST_LAST = CW'(GHOST_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    seg7_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic          wrap;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        wrap    = 1'b0;
        if (!enable) begin
            state_n = ST_OFF;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
                ST_BLANK: begin
                    if (cnt == GHOST_LAST) begin
                        state_n = ST_ON;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt == ON_LAST) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        // Explicit compare so non-power-of-two banks never reach DIGITS.
                        if (idx == IDX_LAST) begin
                            idx_n = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_OFF;
            cnt       <= '0;
            idx       <= '0;
            frameDone <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            frameDone <= wrap;
        end
    end

    assign nxtOn  = (state_n == ST_ON);
    assign nxtIdx = idx_n;
    assign isOff  = (state == ST_OFF);

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment driver with frame-synchronous shadow updates.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned ON_CYCLES      = 1000,
    parameter int unsigned GHOST_CYCLES   = 16,
    parameter bit          SEG_ACTIVE_LOW = 1,
    parameter bit          DIG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dpOut,
    output logic [DIGITS-1:0]     digitSel,
    output logic                  frameDone
);

    localparam int unsigned IW = idx_width(DIGITS);
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    logic [4*DIGITS-1:0] staged_val, sh_val, sh_val_n;
    logic [DIGITS-1:0]   staged_dp, sh_dp, sh_dp_n, sel;
    logic                pending, nxt_on, is_off, dot, blank;
    logic [IW-1:0]       nxt_idx;
    logic [3:0]          nib;

    seg7_slot_timer #(
        .DIGITS       (DIGITS),
        .ON_CYCLES    (ON_CYCLES),
        .GHOST_CYCLES (GHOST_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .nxtOn     (nxt_on),
        .nxtIdx    (nxt_idx),
        .isOff     (is_off),
        .frameDone (frameDone)
    );

    always_comb begin
        sh_val_n = sh_val;
        sh_dp_n  = sh_dp;
        if (load && (is_off || frameDone)) begin
            sh_val_n = value;
            sh_dp_n  = dp;
        end else if (frameDone && pending) begin
            sh_val_n = staged_val;
            sh_dp_n  = staged_dp;
        end
    end

    // Decode from next-state and next-shadow so the registered pins change on
    // the same edge the timer enters a slot (a short GHOST cannot show stale data).
    always_comb begin
        nib   = '0;
        dot   = 1'b0;
        blank = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (nxt_idx == IW'(i)) begin
                nib    = sh_val_n[4*i +: 4];
                dot    = sh_dp_n[i];
                sel[i] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                blank  = (i != 0) && ((sh_val_n >> (4*i)) == '0);
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            staged_val <= '0;
            staged_dp  <= '0;
            pending    <= 1'b0;
            sh_val     <= '0;
            sh_dp      <= '0;
        end else begin
            sh_val <= sh_val_n;
            sh_dp  <= sh_dp_n;
            if (load) begin
                staged_val <= value;
                staged_dp  <= dp;
                pending    <= !(is_off || frameDone);
            end else if (frameDone) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg      <= SEG_OFF;
            dpOut    <= DP_OFF;
            digitSel <= SEL_OFF;
        end else if (nxt_on) begin
            seg      <= seg_polarity(blank ? 7'h00 : GLYPH[nib], SEG_ACTIVE_LOW);
            dpOut    <= SEG_ACTIVE_LOW ? ~dot : dot;
            digitSel <= DIG_ACTIVE_LOW ? ~sel : sel;
        end else begin
            seg      <= SEG_OFF;
            dpOut    <= DP_OFF;
            digitSel <= SEL_OFF;
        end
    end

endmodule
